// File: rtl/slice_serial_alu_if.sv
// Handshake and data bundle between the register-read stage, the slice-serial ALU and writeback.
// The slave modport is the ALU side; the master modport is the issuing and consuming side.
interface slice_serial_alu_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/slice_serial_alu.sv
// Multi-cycle ALU: processes WIDTH-bit operands SLICE bits per clock, with a registered inter-slice carry.
// Define SLICE_SERIAL_ALU_FLAGS_EN to build the Z/N/C/V flag logic; otherwise the flag outputs are tied to 0.
module slice_serial_alu #(
  parameter int WIDTH = 64,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  slice_serial_alu_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  logic [SLICE-1:0] a_sl, b_sl, r_sl;
  logic [SLICE:0]   sum;
  logic             last_slice;

  // One slice of the datapath; subtraction inverts B and relies on the carry seeded to 1 at issue.
  always_comb begin
    a_sl = a_q[idx_q*SLICE +: SLICE];
    b_sl = b_q[idx_q*SLICE +: SLICE];
    sum  = {1'b0, a_sl} + {1'b0, (op_q == OP_SUB) ? ~b_sl : b_sl} + {{SLICE{1'b0}}, carry_q};
    case (op_q)
      OP_PASS:        r_sl = b_sl;
      OP_ADD, OP_SUB: r_sl = sum[SLICE-1:0];
      OP_AND:         r_sl = a_sl & b_sl;
      OP_OR:          r_sl = a_sl | b_sl;
      OP_XOR:         r_sl = a_sl ^ b_sl;
      default:        r_sl = '0;
    endcase
  end

  assign last_slice = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          idx_d   = '0;
          carry_d = (bus.op == OP_SUB);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d[idx_q*SLICE +: SLICE] = r_sl;
        carry_d = sum[SLICE];
        if (last_slice) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = res_q;

`ifdef SLICE_SERIAL_ALU_FLAGS_EN
  logic [3:0] flags_q, flags_d;
  logic       a_msb, b_msb, r_msb;

  // Flags are captured on the final RUN cycle from the fully assembled result, so they settle with out_valid.
  always_comb begin
    flags_d = flags_q;
    a_msb   = a_q[WIDTH-1];
    b_msb   = b_q[WIDTH-1];
    r_msb   = res_d[WIDTH-1];
    if (state_q == S_RUN && last_slice) begin
      flags_d[3] = (res_d == '0);
      flags_d[2] = r_msb;
      flags_d[1] = ((op_q == OP_ADD) || (op_q == OP_SUB)) && sum[SLICE];
      case (op_q)
        OP_ADD:  flags_d[0] = (a_msb == b_msb) && (r_msb != a_msb);
        OP_SUB:  flags_d[0] = (a_msb != b_msb) && (r_msb != a_msb);
        default: flags_d[0] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flags_q <= '0;
    else          flags_q <= flags_d;
  end

  assign bus.flag_z = flags_q[3];
  assign bus.flag_n = flags_q[2];
  assign bus.flag_c = flags_q[1];
  assign bus.flag_v = flags_q[0];
`else
  assign bus.flag_z = 1'b0;
  assign bus.flag_n = 1'b0;
  assign bus.flag_c = 1'b0;
  assign bus.flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_slice_serial_alu.sv
// Directed bench for slice_serial_alu (WIDTH=64, SLICE=8): vector table plus handshake and reset sequences.
module tb_slice_serial_alu;
  localparam int WIDTH = 64;
  localparam int SLICE = 8;
  localparam int NSLICE = WIDTH / SLICE;
`ifdef SLICE_SERIAL_ALU_FLAGS_EN
  localparam logic [3:0] FLAG_MASK = 4'hF;
`else
  localparam logic [3:0] FLAG_MASK = 4'h0;
`endif

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic [63:0] res;
    logic [3:0]  zncv;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;
  vec_t vecs[13];

  slice_serial_alu_if #(.WIDTH(WIDTH)) bus ();

  slice_serial_alu #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags_now();
    return {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v};
  endfunction

  // Issue one operation, then scramble the inputs; returns edges from acceptance to out_valid.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.op = op;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = ~a;
    bus.b = ~b;
    bus.op = 3'b001;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
    chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    logic [63:0] held;
    logic [3:0]  held_f;
    n_cmp = 0;
    n_err = 0;

    vecs[0]  = '{64'h00000000_FFFFFFFF, 64'd1, 3'b010, 64'h00000001_00000000, 4'b0000};
    vecs[1]  = '{64'hFFFFFFFF_FFFFFFFF, 64'd1, 3'b010, 64'h0, 4'b1010};
    vecs[2]  = '{64'h80000000_00000000, 64'd1, 3'b011, 64'h7FFFFFFF_FFFFFFFF, 4'b0011};
    vecs[3]  = '{64'd5, 64'd7, 3'b011, 64'hFFFFFFFF_FFFFFFFE, 4'b0100};
    vecs[4]  = '{64'hF0F0F0F0_F0F0F0F0, 64'hFF00FF00_FF00FF00, 3'b100, 64'hF000F000_F000F000, 4'b0100};
    vecs[5]  = '{64'hF0F0F0F0_F0F0F0F0, 64'hFF00FF00_FF00FF00, 3'b101, 64'hFFF0FFF0_FFF0FFF0, 4'b0100};
    vecs[6]  = '{64'hF0F0F0F0_F0F0F0F0, 64'hFF00FF00_FF00FF00, 3'b110, 64'h0FF00FF0_0FF00FF0, 4'b0000};
    vecs[7]  = '{64'hF0F0F0F0_F0F0F0F0, 64'hFF00FF00_FF00FF00, 3'b000, 64'hFF00FF00_FF00FF00, 4'b0100};
    vecs[8]  = '{64'hF0F0F0F0_F0F0F0F0, 64'hFF00FF00_FF00FF00, 3'b111, 64'h0, 4'b1000};
    vecs[9]  = '{64'hF0F0F0F0_F0F0F0F0, 64'hFF00FF00_FF00FF00, 3'b001, 64'h0, 4'b1000};
    vecs[10] = '{64'd5, 64'd5, 3'b011, 64'h0, 4'b1010};
    vecs[11] = '{64'h7FFFFFFF_FFFFFFFF, 64'd1, 3'b010, 64'h80000000_00000000, 4'b0101};
    vecs[12] = '{64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, 3'b010, 64'h22222222_22222211, 4'b0000};

    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.op = '0;
    #12;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_flags", 64'(flags_now()), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(NSLICE));
      chk($sformatf("v%0d_result", i), bus.result, vecs[i].res);
      chk($sformatf("v%0d_zncv", i), 64'(flags_now()), 64'(vecs[i].zncv & FLAG_MASK));
      chk($sformatf("v%0d_busy", i), 64'(bus.in_ready), 64'd0);
      $display("vec %0d: a=%h b=%h op=%b -> result=%h zncv=%b lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].op, bus.result, flags_now(), lat);
      release_result();
    end

    // Back-pressure: result held in DONE for 5 cycles while a stray in_valid is offered.
    run_op(64'h1234, 64'h1111, 3'b010, lat);
    chk("hs_latency", 64'(lat), 64'(NSLICE));
    held = bus.result;
    held_f = flags_now();
    chk("hs_result", held, 64'h2345);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.in_valid = (c == 1);
      bus.a = 64'hDEAD;
      bus.b = 64'hBEEF;
      bus.op = 3'b110;
      @(posedge clk);
      #1;
      chk($sformatf("hs_hold%0d_valid", c), 64'(bus.out_valid), 64'd1);
      chk($sformatf("hs_hold%0d_in_ready", c), 64'(bus.in_ready), 64'd0);
      chk($sformatf("hs_hold%0d_result", c), bus.result, held);
      chk($sformatf("hs_hold%0d_flags", c), 64'(flags_now()), 64'(held_f));
    end
    bus.in_valid = 1'b0;
    release_result();
    @(posedge clk);
    #1;
    chk("hs_not_queued", 64'(bus.in_ready), 64'd1);
    $display("handshake: held result=%h for 5 cycles, stray in_valid dropped", held);

    // Asynchronous reset in the middle of RUN, after three slices have been written.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 64'h11111111_11111111;
    bus.b = 64'h22222222_22222222;
    bus.op = 3'b010;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_result", bus.result, 64'd0);
    chk("mid_rst_flags", 64'(flags_now()), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    run_op(64'd2, 64'd3, 3'b010, lat);
    chk("post_rst_latency", 64'(lat), 64'(NSLICE));
    chk("post_rst_result", bus.result, 64'd5);
    chk("post_rst_flags", 64'(flags_now()), 64'd0);
    $display("reset mid-RUN: fresh 2+3 -> %h after %0d cycles", bus.result, lat);
    release_result();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
